// File: rtl/dmem_pkt_tx.sv
// dmem_pkt_tx: reads a block of data memory and emits it as one packet on the 64-bit datapath.
// Optional feature macro: DMEM_TX_HDR_EN prepends the module header word.
module dmem_pkt_tx #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned DM_ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DM_ADDR_WIDTH-1:0] base_addr,
    input  logic [DM_ADDR_WIDTH:0]   num_words,
    input  logic [15:0]              dst_port,
    input  logic [15:0]              src_port,
    output logic [DM_ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]    dm_rd_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CTRL_WIDTH-1:0]    out_ctrl,
    output logic                     out_wr,
    input  logic                     out_rdy,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              pkt_count
);

    localparam int unsigned CntW = DM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StHdr, StData, StDone} state_e;

    state_e                   state_q, state_d;
    logic [DM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CntW-1:0]          num_q, num_d;
    logic [CntW-1:0]          issued_q, issued_d;
    logic [CntW-1:0]          sent_q, sent_d;
    logic                     rd_pend_q, rd_pend_d;
    logic                     hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]    hold_q, hold_d;
    logic [31:0]              pkt_count_q, pkt_count_d;

    logic                     word_avail;
    logic [DATA_WIDTH-1:0]    word_data;
    logic                     word_take;
    logic                     last_word;
    logic                     rd_issue;

`ifdef DMEM_TX_HDR_EN
    logic [15:0] dst_q;
    logic [15:0] src_q;
    logic [63:0] hdr_word;

    assign hdr_word = {dst_q, 16'(num_q), src_q, 16'({num_q, 3'b000})};

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_q <= '0;
            src_q <= '0;
        end else if (state_q == StIdle && start) begin
            dst_q <= dst_port;
            src_q <= src_port;
        end
    end
`else
    logic unused_hdr_ports;
    assign unused_hdr_ports = ^{dst_port, src_port};
`endif

    // Exactly one word is ever in flight: either returning from memory or parked in hold_q.
    assign word_avail = hold_valid_q | rd_pend_q;
    assign word_data  = hold_valid_q ? hold_q : dm_rd_data;
    assign word_take  = (state_q == StData) && word_avail && out_rdy;
    assign last_word  = (sent_q == num_q - CntW'(1));
    assign rd_issue   = ((state_q == StHdr) || (state_q == StData)) && (issued_q != num_q) &&
                        (!word_avail || word_take);

    assign busy      = (state_q != StIdle);
    assign pkt_count = pkt_count_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        num_d        = num_q;
        issued_d     = issued_q;
        sent_d       = sent_q;
        rd_pend_d    = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        pkt_count_d  = pkt_count_q;
        dm_addr      = addr_q;
        out_data     = '0;
        out_ctrl     = '0;
        out_wr       = 1'b0;
        done         = 1'b0;

        if (rd_pend_q && !word_take) begin
            hold_valid_d = 1'b1;
            hold_d       = dm_rd_data;
        end else if (hold_valid_q && word_take) begin
            hold_valid_d = 1'b0;
        end

        if (rd_issue) begin
            rd_pend_d = 1'b1;
            addr_d    = addr_q + DM_ADDR_WIDTH'(1);
            issued_d  = issued_q + CntW'(1);
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    num_d        = num_words;
                    sent_d       = '0;
                    issued_d     = '0;
                    hold_valid_d = 1'b0;
                    addr_d       = base_addr;
                    if (num_words == '0) begin
                        state_d     = StDone;
                        pkt_count_d = pkt_count_q + 32'd1;
                    end else begin
`ifdef DMEM_TX_HDR_EN
                        state_d = StHdr;
`else
                        // Without a header the first read goes out in the start cycle.
                        state_d   = StData;
                        dm_addr   = base_addr;
                        rd_pend_d = 1'b1;
                        addr_d    = base_addr + DM_ADDR_WIDTH'(1);
                        issued_d  = CntW'(1);
`endif
                    end
                end
            end
            StHdr: begin
`ifdef DMEM_TX_HDR_EN
                out_data = DATA_WIDTH'(hdr_word);
                out_ctrl = '1;
                out_wr   = out_rdy;
                if (out_rdy) begin
                    state_d = StData;
                end
`else
                state_d = StIdle;
`endif
            end
            StData: begin
                if (word_avail) begin
                    out_data = word_data;
                    out_ctrl = last_word ? CTRL_WIDTH'(1) : '0;
                    out_wr   = out_rdy;
                end
                if (word_take) begin
                    sent_d = sent_q + CntW'(1);
                    if (last_word) begin
                        state_d     = StDone;
                        pkt_count_d = pkt_count_q + 32'd1;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            num_q        <= '0;
            issued_q     <= '0;
            sent_q       <= '0;
            rd_pend_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            issued_q     <= issued_d;
            sent_q       <= sent_d;
            rd_pend_q    <= rd_pend_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_dmem_pkt_tx.sv
// tb_dmem_pkt_tx: table vectors, randomized packets and reset/backpressure sequences for dmem_pkt_tx.
module tb_dmem_pkt_tx;

`ifdef DMEM_TX_HDR_EN
    localparam bit HdrEn = 1'b1;
`else
    localparam bit HdrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic [15:0] dst_port;
    logic [15:0] src_port;
    logic [7:0]  dm_addr;
    logic [63:0] dm_rd_data;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        busy;
    logic        done;
    logic [31:0] pkt_count;

    dmem_pkt_tx dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .dst_port   (dst_port),
        .src_port   (src_port),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .busy       (busy),
        .done       (done),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [256];
    always @(posedge clk) dm_rd_data <= mem[dm_addr];

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
    } word_t;

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  num;
        logic [15:0] dst;
        logic [15:0] src;
        int          mode;
        bit          poke;
        logic [63:0] hdr;
        logic [63:0] first;
        int          lat;
    } vec_t;

    word_t       exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          pkt_words = 0;
    int          model_pkts = 0;
    bit          mon_en = 1'b0;
    bit          in_pkt = 1'b0;
    bit          saw_done = 1'b0;
    logic [63:0] first_word;
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic monitor();
        word_t w;
        if (out_wr) begin
            check("wr_needs_rdy", 64'(out_rdy), 64'd1);
            if (pkt_words == 0) first_word = out_data;
            pkt_words++;
            if (exp_q.size() == 0) begin
                check("extra_word", 64'(out_wr), 64'd0);
            end else begin
                w = exp_q.pop_front();
                check("word_data", out_data, w.d);
                check("word_ctrl", 64'(out_ctrl), 64'(w.c));
            end
        end
        if (done) begin
            check("done_expected", 64'(in_pkt), 64'd1);
            saw_done = 1'b1;
            done_cyc = cyc;
        end
    endtask

    // Entered just after a rising edge with inputs set; samples mid-cycle, then advances.
    task automatic run_cycle();
        #1;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        repeat (3) run_cycle();
        reset      = 1'b0;
        mon_en     = 1'b1;
        in_pkt     = 1'b0;
        model_pkts = 0;
        exp_q.delete();
    endtask

    task automatic build_exp(input logic [7:0] base, input logic [8:0] num,
                             input logic [15:0] dst, input logic [15:0] src);
        exp_q.delete();
        if (HdrEn) exp_q.push_back('{d: {dst, 16'(num), src, 16'(int'(num) * 8)}, c: 8'hFF});
        for (int i = 0; i < int'(num); i++)
            exp_q.push_back('{d: mem[(int'(base) + i) % 256],
                              c: (i == int'(num) - 1) ? 8'h01 : 8'h00});
        pkt_words = 0;
    endtask

    task automatic send_pkt(input logic [7:0] base, input logic [8:0] num, input logic [15:0] dst,
                            input logic [15:0] src, input int mode, input bit poke,
                            input int lat, input bit chk_first, input logic [63:0] want_first);
        int t0;
        build_exp(base, num, dst, src);
        base_addr = base;
        num_words = num;
        dst_port  = dst;
        src_port  = src;
        out_rdy   = 1'b1;
        start     = 1'b1;
        in_pkt    = 1'b1;
        saw_done  = 1'b0;
        t0        = cyc;
        run_cycle();
        start = 1'b0;
        for (int it = 0; it < 3000 && !saw_done; it++) begin
            case (mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = pat[it % 6];
                default: out_rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (poke && it == 2) begin
                start     = 1'b1;
                base_addr = base + 8'h33;
                num_words = num + 9'd3;
                dst_port  = ~dst;
            end else begin
                start = 1'b0;
            end
            if (it == 0) begin
                #1;
                check("busy_rise", 64'(busy), 64'd1);
            end
            run_cycle();
        end
        start  = 1'b0;
        in_pkt = 1'b0;
        check("done_seen", 64'(saw_done), 64'd1);
        if (saw_done) begin
            check("words_left", 64'(exp_q.size()), 64'd0);
            model_pkts++;
            check("pkt_count", 64'(pkt_count), 64'(model_pkts));
            #1;
            check("busy_fall", 64'(busy), 64'd0);
            if (lat > 0) check("done_latency", 64'(done_cyc - t0), 64'(lat));
            if (chk_first && num != 0) check("first_word", first_word, want_first);
        end else begin
            do_reset();
        end
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs[8];
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        dst_port  = '0;
        src_port  = '0;
        out_rdy   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 64'(i);

        do_reset();
        #1;
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_dm_addr", 64'(dm_addr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);

        // Latencies assume the header build; the headerless build is one cycle earlier.
        vecs[0] = '{8'h10, 9'd4,   16'h0001, 16'h0000, 0, 1'b0, 64'h0001_0004_0000_0020, 64'h10, 6};
        vecs[1] = '{8'hFE, 9'd4,   16'h0002, 16'h0003, 0, 1'b0, 64'h0002_0004_0003_0020, 64'hFE, 6};
        vecs[2] = '{8'h10, 9'd4,   16'h0001, 16'h0000, 1, 1'b0, 64'h0001_0004_0000_0020, 64'h10, 0};
        vecs[3] = '{8'h20, 9'd0,   16'h0004, 16'h0005, 0, 1'b0, 64'h0, 64'h0, 1};
        vecs[4] = '{8'hFF, 9'd1,   16'h8000, 16'h0010, 0, 1'b0, 64'h8000_0001_0010_0008, 64'hFF, 3};
        vecs[5] = '{8'h00, 9'd256, 16'h0001, 16'h0002, 0, 1'b0, 64'h0001_0100_0002_0800, 64'h00, 258};
        vecs[6] = '{8'h40, 9'd5,   16'h0010, 16'h0020, 2, 1'b1, 64'h0010_0005_0020_0028, 64'h40, 0};
        vecs[7] = '{8'h80, 9'd3,   16'h0004, 16'hFFFF, 1, 1'b1, 64'h0004_0003_FFFF_0018, 64'h80, 0};

        for (int v = 0; v < 8; v++) begin
            send_pkt(vecs[v].base, vecs[v].num, vecs[v].dst, vecs[v].src, vecs[v].mode,
                     vecs[v].poke,
                     (HdrEn || vecs[v].num == 0) ? vecs[v].lat :
                         (vecs[v].lat > 0 ? vecs[v].lat - 1 : 0),
                     1'b1, HdrEn ? vecs[v].hdr : vecs[v].first);
            run_cycle();
        end

        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};

        for (int p = 0; p < 25; p++) begin
            logic [7:0]  b;
            logic [8:0]  n;
            int          m;
            int          lat;
            bit          pk;
            b   = 8'($urandom);
            n   = ($urandom_range(0, 9) == 0) ? 9'd256 : 9'($urandom_range(0, 24));
            m   = $urandom_range(0, 2);
            pk  = (n >= 9'd3) && ($urandom_range(0, 3) == 0);
            lat = (m != 0) ? 0 : (n == 0 ? 1 : int'(n) + (HdrEn ? 2 : 1));
            send_pkt(b, n, 16'($urandom), 16'($urandom), m, pk, lat, 1'b0, 64'd0);
            repeat ($urandom_range(0, 2)) run_cycle();
        end

        // Reset lands in the cycle that would carry payload word 2.
        build_exp(8'hF0, 9'd6, 16'h0002, 16'h0001);
        base_addr = 8'hF0;
        num_words = 9'd6;
        dst_port  = 16'h0002;
        src_port  = 16'h0001;
        out_rdy   = 1'b1;
        start     = 1'b1;
        in_pkt    = 1'b1;
        run_cycle();
        start = 1'b0;
        for (int it = 0; it < 50 && pkt_words < (HdrEn ? 3 : 2); it++) run_cycle();
        check("pre_reset_words", 64'(pkt_words), 64'(HdrEn ? 3 : 2));
        mon_en = 1'b0;
        reset  = 1'b1;
        run_cycle();
        reset  = 1'b0;
        mon_en = 1'b1;
        in_pkt = 1'b0;
        exp_q.delete();
        model_pkts = 0;
        #1;
        check("mid_rst_out_wr", 64'(out_wr), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
        send_pkt(8'hF0, 9'd6, 16'h0002, 16'h0001, 0, 1'b0, HdrEn ? 8 : 7, 1'b1,
                 HdrEn ? 64'h0002_0006_0001_0030 : mem[8'hF0]);
        run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
